// File: rtl/led_status_ctrl.sv
// Multi-channel LED status driver: prescaled tick, shared blink phase, per-channel
// activity stretching, lamp test, and a registered, polarity-selectable pin drive.
// The activity strobe port is named 'events' because 'event' is a reserved word.
module led_status_ctrl #(
  parameter int NUM_LEDS      = 4,
  parameter int PRESCALE_W    = 24,
  parameter int STRETCH_TICKS = 3,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*NUM_LEDS-1:0] mode,
  input  logic [NUM_LEDS-1:0]   events,
  input  logic                  lamp_test,
  output logic [NUM_LEDS-1:0]   led,
  output logic                  tick
);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_ACT   = 2'b11
  } mode_e;

  logic [PRESCALE_W-1:0] presc;
  logic                  blink;
  logic [7:0]            stretch     [NUM_LEDS];
  logic [7:0]            stretch_nxt [NUM_LEDS];
  logic [NUM_LEDS-1:0]   led_q;
  logic [NUM_LEDS-1:0]   led_d;
  mode_e                 ch_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      tick  <= 1'b0;
      blink <= 1'b0;
      led_q <= '0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        stretch[i] <= '0;
      end
    end else begin
      presc <= presc + 1'b1;
      tick  <= &presc;
      blink <= blink ^ tick;
      led_q <= led_d;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        stretch[i] <= stretch_nxt[i];
      end
    end
  end

  // Activity display uses the next counter value so the LED releases in the
  // cycle right after the final decrementing tick, and an event lights it at once.
  always_comb begin
    led_d   = '0;
    ch_mode = MODE_OFF;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      stretch_nxt[i] = stretch[i];
      if (events[i]) begin
        stretch_nxt[i] = 8'(STRETCH_TICKS);
      end else if (tick && (stretch[i] != 8'd0)) begin
        stretch_nxt[i] = stretch[i] - 8'd1;
      end
      ch_mode = mode_e'(mode[2*i +: 2]);
      case (ch_mode)
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = blink;
        MODE_ACT:   led_d[i] = (stretch_nxt[i] != 8'd0);
        default:    led_d[i] = 1'b0;
      endcase
      if (lamp_test) begin
        led_d[i] = 1'b1;
      end
    end
  end

  assign led = (ACTIVE_LOW != 0) ? ~led_q : led_q;

endmodule
